// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready handshaked ALU with registered result, NZCV flags and pass-through tag.
// Define ALU_MUL_EN to build the iterative radix-2 multiplier (opcode 1111, WIDTH-cycle latency).
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inOne,
    input  logic [WIDTH-1:0] inTwo,
    input  logic [3:0]       opcode,
    input  logic [TAG_W-1:0] inTag,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] outTag,
    output logic             zeroFlag,
    output logic             negFlag,
    output logic             carryBit,
    output logic             overflowFlag,
    output logic             illegalOp
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b1011;
    localparam logic [3:0] OP_ASR  = 4'b1110;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1111;
`endif

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_result;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_zero;
    logic              r_neg;
    logic              r_carry;
    logic              r_ovf;
    logic              r_illegal;

    logic              w_accept;
    logic              w_start_mul;
    logic              w_mul_done;
    logic              w_load;

    logic [SH_W-1:0]   w_shamt;
    logic [WIDTH:0]    w_add_full;
    logic [WIDTH:0]    w_sub_full;
    logic [WIDTH:0]    w_lsl_full;
    logic [WIDTH:0]    w_lsr_full;
    logic signed [WIDTH:0] w_asr_full;

    logic [WIDTH-1:0]  w_alu_res;
    logic              w_alu_c;
    logic              w_alu_v;
    logic              w_alu_ill;

    logic [WIDTH-1:0]  w_mul_res;
    logic              w_mul_c;
    logic [TAG_W-1:0]  w_mul_tag;

    logic [WIDTH-1:0]  w_fin_res;
    logic              w_fin_c;
    logic              w_fin_v;
    logic              w_fin_ill;
    logic [TAG_W-1:0]  w_fin_tag;

    assign w_accept = inValid && inReady;
    assign w_load   = w_accept && !w_start_mul;

    // Shifts keep one extra bit so the last bit shifted out lands in a fixed position.
    assign w_shamt    = inTwo[SH_W-1:0];
    assign w_add_full = {1'b0, inOne} + {1'b0, inTwo};
    assign w_sub_full = {1'b0, inOne} - {1'b0, inTwo};
    assign w_lsl_full = {1'b0, inOne} << w_shamt;
    assign w_lsr_full = {inOne, 1'b0} >> w_shamt;
    assign w_asr_full = $signed({inOne, 1'b0}) >>> w_shamt;

    // Single-cycle ALU: result plus carry/overflow for the presented opcode.
    always_comb begin
        w_alu_res   = {WIDTH{1'b0}};
        w_alu_c     = 1'b0;
        w_alu_v     = 1'b0;
        w_alu_ill   = 1'b0;
        w_start_mul = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_res = w_add_full[WIDTH-1:0];
                w_alu_c   = w_add_full[WIDTH];
                w_alu_v   = (inOne[WIDTH-1] == inTwo[WIDTH-1]) &&
                            (w_add_full[WIDTH-1] != inOne[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub_full[WIDTH-1:0];
                w_alu_c   = ~w_sub_full[WIDTH];
                w_alu_v   = (inOne[WIDTH-1] != inTwo[WIDTH-1]) &&
                            (w_sub_full[WIDTH-1] != inOne[WIDTH-1]);
            end
            OP_AND:  w_alu_res = inOne & inTwo;
            OP_OR:   w_alu_res = inOne | inTwo;
            OP_XOR:  w_alu_res = inOne ^ inTwo;
            OP_NOR:  w_alu_res = ~(inOne | inTwo);
            OP_NAND: w_alu_res = ~(inOne & inTwo);
            OP_MOV:  w_alu_res = inOne;
            OP_CBZ:  w_alu_res = {WIDTH{1'b0}};
            OP_LSL: begin
                w_alu_res = w_lsl_full[WIDTH-1:0];
                w_alu_c   = w_lsl_full[WIDTH];
            end
            OP_LSR: begin
                w_alu_res = w_lsr_full[WIDTH:1];
                w_alu_c   = w_lsr_full[0];
            end
            OP_ASR: begin
                w_alu_res = w_asr_full[WIDTH:1];
                w_alu_c   = w_asr_full[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL:  w_start_mul = 1'b1;
`endif
            default: w_alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [SH_W-1:0]    r_cnt;
    logic [TAG_W-1:0]   r_mul_tag;
    logic [WIDTH:0]     w_partial;
    logic [2*WIDTH-1:0] w_acc_next;

    // Low half of the accumulator holds the unconsumed multiplier bits, LSB first.
    assign w_partial  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_partial, r_acc[WIDTH-1:1]};
    assign w_mul_done = (r_state == ST_MUL_BUSY) && (r_cnt == {SH_W{1'b0}});
    assign w_mul_res  = w_acc_next[WIDTH-1:0];
    assign w_mul_c    = |w_acc_next[2*WIDTH-1:WIDTH];
    assign w_mul_tag  = r_mul_tag;

    // Shift-add datapath: load on accept, one multiplier bit per busy cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_acc     <= {(2*WIDTH){1'b0}};
            r_mcand   <= {WIDTH{1'b0}};
            r_cnt     <= {SH_W{1'b0}};
            r_mul_tag <= {TAG_W{1'b0}};
        end else if (w_accept && w_start_mul) begin
            r_acc     <= {{WIDTH{1'b0}}, inTwo};
            r_mcand   <= inOne;
            r_cnt     <= SH_W'(WIDTH - 1);
            r_mul_tag <= inTag;
        end else if (r_state == ST_MUL_BUSY) begin
            r_acc <= w_acc_next;
            if (r_cnt != {SH_W{1'b0}}) begin
                r_cnt <= r_cnt - {{(SH_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign w_mul_done = 1'b0;
    assign w_mul_res  = {WIDTH{1'b0}};
    assign w_mul_c    = 1'b0;
    assign w_mul_tag  = {TAG_W{1'b0}};
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_start_mul) begin
                    w_state_next = ST_MUL_BUSY;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                if (w_mul_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_MUL_BUSY;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the output register is empty or draining.
    always_comb begin
        inReady = 1'b0;
        if (resetN && (r_state == ST_IDLE) && (!r_out_valid || outReady)) begin
            inReady = 1'b1;
        end else begin
            inReady = 1'b0;
        end
    end

    // Select what the output register captures: a finishing multiply or the current ALU op.
    always_comb begin
        w_fin_res = w_alu_res;
        w_fin_c   = w_alu_c;
        w_fin_v   = w_alu_v;
        w_fin_ill = w_alu_ill;
        w_fin_tag = inTag;
        if (w_mul_done) begin
            w_fin_res = w_mul_res;
            w_fin_c   = w_mul_c;
            w_fin_v   = 1'b0;
            w_fin_ill = 1'b0;
            w_fin_tag = w_mul_tag;
        end else begin
            w_fin_res = w_alu_res;
            w_fin_c   = w_alu_c;
            w_fin_v   = w_alu_v;
            w_fin_ill = w_alu_ill;
            w_fin_tag = inTag;
        end
    end

    // Output register: load a new result, drain on transfer, otherwise hold.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_out_tag   <= {TAG_W{1'b0}};
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_load || w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_fin_res;
            r_out_tag   <= w_fin_tag;
            r_zero      <= (w_fin_res == {WIDTH{1'b0}});
            r_neg       <= w_fin_res[WIDTH-1];
            r_carry     <= w_fin_c;
            r_ovf       <= w_fin_v;
            r_illegal   <= w_fin_ill;
        end else if (r_out_valid && outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outValid     = r_out_valid;
    assign result       = r_result;
    assign outTag       = r_out_tag;
    assign zeroFlag     = r_zero;
    assign negFlag      = r_neg;
    assign carryBit     = r_carry;
    assign overflowFlag = r_ovf;
    assign illegalOp    = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed corner vectors plus randomized traffic
// checked against an arithmetic reference model; honours ALU_MUL_EN in the expected behaviour.
module tb_alu_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
`ifdef ALU_MUL_EN
    localparam int MUL_LAT = WIDTH;
`else
    localparam int MUL_LAT = 1;
`endif

    logic             clock    = 1'b0;
    logic             resetN   = 1'b0;
    logic             inValid  = 1'b0;
    logic             inReady;
    logic [31:0]      inOne    = 32'd0;
    logic [31:0]      inTwo    = 32'd0;
    logic [3:0]       opcode   = 4'd0;
    logic [4:0]       inTag    = 5'd0;
    logic             outValid;
    logic             outReady = 1'b1;
    logic [31:0]      result;
    logic [4:0]       outTag;
    logic             zeroFlag, negFlag, carryBit, overflowFlag, illegalOp;

    int n_checks = 0;
    int n_pass   = 0;
    int bp_mode  = 0;   // 0: always ready, 1: never ready, 2: random

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        n, z, c, v, ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_stall = 1'b0;

    logic [3:0] tp_ops [8] = '{4'b0010, 4'b1010, 4'b0110, 4'b0100,
                               4'b1001, 4'b0101, 4'b1100, 4'b0011};

    alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .resetN(resetN),
        .inValid(inValid), .inReady(inReady),
        .inOne(inOne), .inTwo(inTwo), .opcode(opcode), .inTag(inTag),
        .outValid(outValid), .outReady(outReady),
        .result(result), .outTag(outTag),
        .zeroFlag(zeroFlag), .negFlag(negFlag), .carryBit(carryBit),
        .overflowFlag(overflowFlag), .illegalOp(illegalOp)
    );

    initial forever #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: plain wide arithmetic on the architectural rules.
    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] tag);
        exp_t e;
        longint unsigned ua, ub, full, tmp;
        longint sa, sb, sres;
        int sh;
        e    = '0;
        ua   = 64'(a);
        ub   = 64'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sh   = int'(b[4:0]);
        full = 64'd0;
        tmp  = 64'd0;
        sres = 64'sd0;
        e.tag = tag;
        case (op)
            4'b0010: begin
                full = ua + ub;
                e.c  = (full > 64'hFFFF_FFFF);
                sres = sa + sb;
                e.v  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'b1010: begin
                full = ua - ub;
                e.c  = (ua >= ub);
                sres = sa - sb;
                e.v  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'b0110: full = ua & ub;
            4'b0100: full = ua | ub;
            4'b1001: full = ua ^ ub;
            4'b0101: full = ~(ua | ub);
            4'b1100: full = ~(ua & ub);
            4'b1101: full = ua;
            4'b0111: full = 64'd0;
            4'b0011: begin
                full = ua << sh;
                e.c  = (sh != 0) && full[32];
            end
            4'b1011: begin
                full = ua >> sh;
                if (sh != 0) begin
                    tmp = ua >> (sh - 1);
                    e.c = tmp[0];
                end
            end
            4'b1110: begin
                sres = sa >>> sh;
                full = 64'(sres);
                if (sh != 0) begin
                    tmp = 64'(sa >>> (sh - 1));
                    e.c = tmp[0];
                end
            end
`ifdef ALU_MUL_EN
            4'b1111: begin
                full = ua * ub;
                e.c  = ((full >> 32) != 64'd0);
            end
`endif
            default: begin
                full  = 64'd0;
                e.ill = 1'b1;
            end
        endcase
        e.res = full[31:0];
        e.z   = (e.res == 32'd0);
        e.n   = e.res[31];
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: scoreboard every output cycle against the front of the expected queue.
    initial forever begin
        @(negedge clock);
        if (!resetN) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check_eq("hold_valid", 64'(outValid), 64'd1);
            if (outValid && exp_q.size() == 0) begin
                check_eq("unexpected_out", 64'(outValid), 64'd0);
            end else if (outValid) begin
                mon_e = exp_q[0];
                check_eq("result", 64'(result), 64'(mon_e.res));
                check_eq("tag", 64'(outTag), 64'(mon_e.tag));
                check_eq("nzcv", 64'({negFlag, zeroFlag, carryBit, overflowFlag}),
                         64'({mon_e.n, mon_e.z, mon_e.c, mon_e.v}));
                check_eq("illegal", 64'(illegalOp), 64'(mon_e.ill));
                if (outReady) void'(exp_q.pop_front());
            end
            prev_stall = outValid && !outReady;
            if (inValid && inReady) exp_q.push_back(ref_model(opcode, inOne, inTwo, inTag));
        end
    end

    // Consumer backpressure, applied shortly after each rising edge.
    initial forever begin
        @(posedge clock);
        #2;
        case (bp_mode)
            0:       outReady = 1'b1;
            1:       outReady = 1'b0;
            default: outReady = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Present one op and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        int budget = 100;
        opcode  = op;
        inOne   = a;
        inTwo   = b;
        inTag   = tag;
        inValid = 1'b1;
        @(negedge clock);
        while (!inReady && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check_eq("accept", 64'(inReady), 64'd1);
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 200;
        @(negedge clock);
        while ((exp_q.size() != 0 || outValid) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic measure_lat(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag, input int exp_lat);
        int lat = 1;
        send(op, a, b, tag);
        @(negedge clock);
        while (!outValid && lat < 100) begin
            check_eq("busy_inready", 64'(inReady), 64'd0);
            lat++;
            @(negedge clock);
        end
        check_eq(name, 64'(lat), 64'(exp_lat));
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state.
        #1;
        check_eq("rst_outvalid", 64'(outValid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_tag", 64'(outTag), 64'd0);
        check_eq("rst_flags", 64'({negFlag, zeroFlag, carryBit, overflowFlag, illegalOp}), 64'd0);
        check_eq("rst_inready", 64'(inReady), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;

        // Corner vectors.
        send(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd1);
        send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd2);
        send(4'b1010, 32'd5,         32'd7,         5'd3);
        send(4'b1010, 32'd7,         32'd5,         5'd4);
        send(4'b0011, 32'h8000_0001, 32'd1,         5'd5);
        send(4'b1110, 32'h8000_0000, 32'd31,        5'd6);
        send(4'b1011, 32'hDEAD_BEEF, 32'd0,         5'd7);
        send(4'b0000, 32'h1234_5678, 32'h9ABC_DEF0, 5'h1F);
        send(4'b0101, 32'd0,         32'd0,         5'd8);
        send(4'b0111, 32'h1234_5678, 32'd0,         5'd9);
        send(4'b1101, 32'hCAFE_F00D, 32'd0,         5'd10);
        send(4'b1100, 32'hFFFF_0000, 32'hFF00_FF00, 5'd11);
        wait_drain();

        // Latency: single-cycle op and multiply (or its illegal fallback).
        measure_lat("lat_add", 4'b0010, 32'd3, 32'd4, 5'd12, 1);
        measure_lat("lat_mul", 4'b1111, 32'h0001_0000, 32'h0001_0000, 5'd13, MUL_LAT);
        measure_lat("lat_mul2", 4'b1111, 32'hFFFF_FFFF, 32'd3, 5'd14, MUL_LAT);
        wait_drain();

        // Throughput: 8 back-to-back ops, results on 8 consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            inValid = 1'b1;
            opcode  = tp_ops[i];
            inOne   = 32'($urandom);
            inTwo   = 32'($urandom);
            inTag   = 5'(i + 16);
            @(negedge clock);
            check_eq("tp_inready", 64'(inReady), 64'd1);
            if (i > 0) check_eq("tp_outvalid", 64'(outValid), 64'd1);
            @(posedge clock);
            #1;
        end
        inValid = 1'b0;
        @(negedge clock);
        check_eq("tp_last_valid", 64'(outValid), 64'd1);
        @(negedge clock);
        check_eq("tp_idle", 64'(outValid), 64'd0);
        @(posedge clock);
        #1;

        // Backpressure: consumer stalls 3 cycles; nothing accepted, result held, nothing lost.
        bp_mode = 1;
        send(4'b1001, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd21);
        inValid = 1'b1;
        opcode  = 4'b0010;
        inOne   = 32'd100;
        inTwo   = 32'd23;
        inTag   = 5'd22;
        repeat (3) begin
            @(negedge clock);
            check_eq("bp_inready", 64'(inReady), 64'd0);
            check_eq("bp_outvalid", 64'(outValid), 64'd1);
            @(posedge clock);
            #1;
        end
        bp_mode = 0;
        @(negedge clock);
        check_eq("bp_resume", 64'(inReady), 64'd1);
        @(posedge clock);
        #1;
        inValid = 1'b0;
        wait_drain();

        // Randomized traffic with random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 5'($urandom));
        end
        bp_mode = 0;
        wait_drain();

        // Asynchronous reset mid-stream.
        send(4'b0010, 32'd1, 32'd2, 5'd3);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("arst_outvalid", 64'(outValid), 64'd0);
        check_eq("arst_result", 64'(result), 64'd0);
        check_eq("arst_flags", 64'({negFlag, zeroFlag, carryBit, overflowFlag, illegalOp}), 64'd0);
        check_eq("arst_inready", 64'(inReady), 64'd0);
        inValid = 1'b1;
        opcode  = 4'b0010;
        inOne   = 32'd9;
        inTwo   = 32'd9;
        @(negedge clock);
        check_eq("arst_inready_hold", 64'(inReady), 64'd0);
        @(posedge clock);
        #1;
        check_eq("arst_outvalid_hold", 64'(outValid), 64'd0);
        inValid = 1'b0;
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;
        send(4'b1010, 32'd50, 32'd8, 5'd30);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
